aes_arbiter: RTL and testbench
==============================

Name: aes_arbiter

Overview:
- Shares one iterative `aes` core (parameterised key length) between N_REQ requesters.
- Round-robin grant. Latches the winner's state/key, resets and enables the core, waits for `done`, then returns ciphertext tagged with the requester ID over a valid/ready response channel.
- Sits between the bus-side requesters and the single `aes` instance; it is the only block driving the core's rst/en/state/key.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- KEY_LEN, 192, key width passed to the core (128/192/256).
- TIMEOUT, 64, max cycles in RUN before abort (used only with the optional feature).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- req_valid  in  N_REQ  per-requester request valid.
- req_ready  out  N_REQ  one-hot accept strobe; high only in IDLE for the granted index.
- req_state  in  N_REQ*128  plaintext per requester; slice i at [i*128+:128].
- req_key  in  N_REQ*KEY_LEN  key per requester; slice i at [i*KEY_LEN+:KEY_LEN].
- rsp_valid  out  1  result valid.
- rsp_ready  in  1  result accepted.
- rsp_data  out  128  ciphertext.
- rsp_id  out  $clog2(N_REQ)  requester index of the result.
- rsp_err  out  1  result aborted by watchdog (tied 0 without the feature).
- aes_rst  out  1  core reset, active-high.
- aes_en  out  1  core enable.
- aes_state  out  128  latched plaintext to the core.
- aes_key  out  KEY_LEN  latched key to the core.
- aes_done  in  1  core completion.
- aes_state_out  in  128  core result.

Behaviour:
- On reset (rst low):
  - state=IDLE, rr_ptr=0.
  - req_ready=0, rsp_valid=0, rsp_data=0, rsp_id=0, rsp_err=0.
  - aes_rst=1, aes_en=0, aes_state=0, aes_key=0.
- FSM has four states: IDLE, CLR, RUN, RESP.
- IDLE:
  - aes_rst=1, aes_en=0.
  - If any req_valid is high, grant the first set index scanning from rr_ptr upward with wrap.
  - req_ready[g] is driven combinationally in the same cycle.
  - On that edge, latch req_state[g], req_key[g] and g; set rr_ptr=(g+1) mod N_REQ; go to CLR.
  - With no valid request, hold.
- CLR: one cycle with aes_rst=1, aes_en=0; go to RUN.
- RUN:
  - aes_rst=0, aes_en=1; aes_state/aes_key are held stable for the whole operation.
  - On aes_done=1, capture aes_state_out into rsp_data, set rsp_id=g and rsp_valid=1; go to RESP.
  - aes_done is sampled only in RUN; it is ignored in all other states.
- RESP:
  - aes_en=0, aes_rst=1.
  - Hold rsp_valid/rsp_data/rsp_id stable until rsp_ready=1.
  - On the rsp_valid&&rsp_ready edge, clear rsp_valid and go to IDLE.
- Throughput: one operation in flight, no new grant before the response handshake completes.
- Latency: grant edge to rsp_valid = 2 + core cycles.
- Boundary conditions:
  - req_valid may drop without a grant; no state is retained for that requester.
  - A requester reasserting immediately after its grant gets lowest priority next round.
  - Simultaneous rsp_ready and new req_valid: the request is granted in the following IDLE cycle, not the same cycle.
  - Reset mid-RUN aborts the operation; no response is produced.
  - N_REQ=1 degenerates to a single-requester sequencer with rr_ptr fixed at 0.

Optional Feature:
- Macro: AES_ARB_TIMEOUT_EN.
- Defined:
  - A counter clears on CLR→RUN and increments each RUN cycle.
  - If it reaches TIMEOUT-1 without aes_done, go to RESP with rsp_data=0, rsp_err=1 and the normal rsp_id.
  - rsp_err clears with rsp_valid.
- Undefined:
  - No counter; RUN waits indefinitely for aes_done.
  - rsp_err is constant 0.

Decomposition:
- Package aes_arb_pkg holds:
  - FSM state enum {IDLE, CLR, RUN, RESP}.
  - BLOCK_W=128.
  - Function id_w(n) = $clog2 with a minimum of 1.
- Sub-module rr_arbiter (N parameter):
  - Inputs: req vector, rr_ptr.
  - Outputs: one-hot grant, binary grant index, any_req.
  - Purely combinational, instantiated once.

Test Plan:
- Single request, KEY_LEN=192: requester 2 sends FIPS-197 C.2 vector (key 000102..17, pt 00112233445566778899aabbccddeeff; byte 0 at bits [7:0]) -> rsp_data=dda97ca4864cdfe06eaf70a0ec0d7191, rsp_id=2, rsp_err=0.
- All four requesters held valid from reset -> grant order 0,1,2,3,0; each rsp_id matches its grant order.
- rsp_ready held low 10 cycles after rsp_valid -> rsp_data/rsp_id stable, no req_ready pulses; release -> next grant issued one cycle after the handshake.
- rst pulsed low mid-RUN -> all outputs return to reset values next edge, rr_ptr=0, no response for the aborted request.
- AES_ARB_TIMEOUT_EN, TIMEOUT=16, core model never asserts done -> rsp_valid after 16 RUN cycles with rsp_err=1, rsp_data=0; next request completes normally.
- aes_done forced high during IDLE and RESP -> ignored: no extra rsp_valid and no change to rsp_data.

Source files
------------

// File: rtl/aes_arb_pkg.sv
// Shared types and helpers for the AES core arbiter.
//   arb_state_e : arbiter FSM states
//   BLOCK_W     : AES block width
//   id_w(n)     : index width for n items, never below 1
package aes_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CLR,
    RUN,
    RESP
  } arb_state_e;

  localparam int unsigned BLOCK_W = 128;

  function automatic int unsigned id_w(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/aes_arbiter_rr.sv
// Combinational round-robin picker: first set request at or above rr_ptr_i,
// wrapping to index 0.
//   req_i     : request vector
//   rr_ptr_i  : highest-priority index this round
//   gnt_o     : one-hot grant
//   gnt_idx_o : binary grant index
//   any_req_o : at least one request set
module rr_arbiter
  import aes_arb_pkg::*;
#(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0]       req_i,
  input  logic [id_w(N)-1:0] rr_ptr_i,
  output logic [N-1:0]       gnt_o,
  output logic [id_w(N)-1:0] gnt_idx_o,
  output logic               any_req_o
);

  localparam int unsigned IW = id_w(N);

  int unsigned   k;
  logic [IW-1:0] kidx;
  logic          found;

  always_comb begin
    gnt_o     = '0;
    gnt_idx_o = '0;
    found     = 1'b0;
    k         = 0;
    kidx      = '0;
    for (int unsigned i = 0; i < N; i++) begin
      // rr_ptr_i < N, so one conditional subtract is enough to wrap
      k = 32'(rr_ptr_i) + i;
      if (k >= N) k = k - N;
      kidx = k[IW-1:0];
      if (!found && req_i[kidx]) begin
        found        = 1'b1;
        gnt_o[kidx]  = 1'b1;
        gnt_idx_o    = kidx;
      end
    end
    any_req_o = |req_i;
  end

endmodule

// File: rtl/aes_arbiter.sv
// Shares one iterative AES core between N_REQ requesters (round-robin).
// Latches the winner's plaintext/key, clears and runs the core, then returns
// the result tagged with the requester index over a valid/ready channel.
// Optional build macro AES_ARB_TIMEOUT_EN adds a RUN watchdog (TIMEOUT cycles)
// that returns rsp_data=0 with rsp_err=1; otherwise rsp_err is tied 0.
// Ports:
//   clk, rst                 : clock, async active-low reset
//   req_valid/req_ready      : per-requester request / one-hot accept (IDLE only)
//   req_state/req_key        : packed per-requester plaintext / key
//   rsp_valid/rsp_ready      : response handshake
//   rsp_data/rsp_id/rsp_err  : ciphertext, requester index, watchdog abort
//   aes_rst/aes_en           : core reset (active-high) / enable
//   aes_state/aes_key        : latched operands to the core
//   aes_done/aes_state_out   : core completion / result
module aes_arbiter
  import aes_arb_pkg::*;
#(
  parameter int unsigned N_REQ   = 4,
  parameter int unsigned KEY_LEN = 192,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req_valid,
  output logic [N_REQ-1:0]         req_ready,
  input  logic [N_REQ*BLOCK_W-1:0] req_state,
  input  logic [N_REQ*KEY_LEN-1:0] req_key,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [BLOCK_W-1:0]       rsp_data,
  output logic [id_w(N_REQ)-1:0]   rsp_id,
  output logic                     rsp_err,
  output logic                     aes_rst,
  output logic                     aes_en,
  output logic [BLOCK_W-1:0]       aes_state,
  output logic [KEY_LEN-1:0]       aes_key,
  input  logic                     aes_done,
  input  logic [BLOCK_W-1:0]       aes_state_out
);

  localparam int unsigned IW = id_w(N_REQ);

  arb_state_e         state_q, state_d;
  logic [IW-1:0]      rr_ptr_q, rr_ptr_d;
  logic [IW-1:0]      gid_q, gid_d;
  logic [IW-1:0]      rsp_id_q, rsp_id_d;
  logic [BLOCK_W-1:0] st_q, st_d;
  logic [KEY_LEN-1:0] key_q, key_d;
  logic [BLOCK_W-1:0] data_q, data_d;
  logic               valid_q, valid_d;

  logic [N_REQ-1:0]   gnt;
  logic [IW-1:0]      gnt_idx;
  logic               any_req;

`ifdef AES_ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = id_w(TIMEOUT);
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               err_q, err_d;
`endif

  rr_arbiter #(
    .N (N_REQ)
  ) u_rr (
    .req_i     (req_valid),
    .rr_ptr_i  (rr_ptr_q),
    .gnt_o     (gnt),
    .gnt_idx_o (gnt_idx),
    .any_req_o (any_req)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      gid_q    <= '0;
      rsp_id_q <= '0;
      st_q     <= '0;
      key_q    <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
`ifdef AES_ARB_TIMEOUT_EN
      cnt_q    <= '0;
      err_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      gid_q    <= gid_d;
      rsp_id_q <= rsp_id_d;
      st_q     <= st_d;
      key_q    <= key_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
`ifdef AES_ARB_TIMEOUT_EN
      cnt_q    <= cnt_d;
      err_q    <= err_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    gid_d     = gid_q;
    rsp_id_d  = rsp_id_q;
    st_d      = st_q;
    key_d     = key_q;
    data_d    = data_q;
    valid_d   = valid_q;
`ifdef AES_ARB_TIMEOUT_EN
    cnt_d     = cnt_q;
    err_d     = err_q;
`endif
    req_ready = '0;
    aes_rst   = 1'b1;
    aes_en    = 1'b0;

    case (state_q)
      IDLE: begin
        if (any_req) begin
          req_ready = gnt;
          st_d      = req_state[gnt_idx*BLOCK_W +: BLOCK_W];
          key_d     = req_key[gnt_idx*KEY_LEN +: KEY_LEN];
          gid_d     = gnt_idx;
          rr_ptr_d  = (gnt_idx == IW'(N_REQ - 1)) ? '0 : gnt_idx + 1'b1;
          state_d   = CLR;
        end
      end
      CLR: begin
`ifdef AES_ARB_TIMEOUT_EN
        cnt_d   = '0;
`endif
        state_d = RUN;
      end
      RUN: begin
        aes_rst = 1'b0;
        aes_en  = 1'b1;
        if (aes_done) begin
          data_d   = aes_state_out;
          rsp_id_d = gid_q;
          valid_d  = 1'b1;
          state_d  = RESP;
        end
`ifdef AES_ARB_TIMEOUT_EN
        else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          data_d   = '0;
          rsp_id_d = gid_q;
          valid_d  = 1'b1;
          err_d    = 1'b1;
          state_d  = RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      RESP: begin
        if (rsp_ready) begin
          valid_d = 1'b0;
`ifdef AES_ARB_TIMEOUT_EN
          err_d   = 1'b0;
`endif
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign rsp_valid = valid_q;
  assign rsp_data  = data_q;
  assign rsp_id    = rsp_id_q;
  assign aes_state = st_q;
  assign aes_key   = key_q;
`ifdef AES_ARB_TIMEOUT_EN
  assign rsp_err   = err_q;
`else
  assign rsp_err   = 1'b0;
`endif

endmodule

// File: tb/tb_aes_arbiter.sv
// Directed bench for aes_arbiter with a behavioural core model and a
// response scoreboard.
module tb_aes_arbiter;

  localparam int unsigned N        = 4;
  localparam int unsigned KL       = 192;
  localparam int unsigned TO       = 16;
  localparam int unsigned CORE_CYC = 3;

  localparam logic [127:0] FIPS_PT  = 128'hffeeddccbbaa99887766554433221100;
  localparam logic [191:0] FIPS_KEY = 192'h17161514131211100f0e0d0c0b0a09080706050403020100;
  localparam logic [127:0] FIPS_CT  = 128'h91710deca070af6ee0df4c86a47ca9dd;
  localparam logic [127:0] GARBAGE  = 128'hdeadbeef_deadbeef_deadbeef_deadbeef;

  logic              clk = 1'b0;
  logic              rst;
  logic [N-1:0]      req_valid;
  logic [N-1:0]      req_ready;
  logic [N*128-1:0]  req_state;
  logic [N*KL-1:0]   req_key;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [127:0]      rsp_data;
  logic [1:0]        rsp_id;
  logic              rsp_err;
  logic              aes_rst;
  logic              aes_en;
  logic [127:0]      aes_state;
  logic [KL-1:0]     aes_key;
  logic              aes_done;
  logic [127:0]      aes_state_out;

  always #5 clk = ~clk;

  aes_arbiter #(
    .N_REQ   (N),
    .KEY_LEN (KL),
    .TIMEOUT (TO)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_state     (req_state),
    .req_key       (req_key),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_data      (rsp_data),
    .rsp_id        (rsp_id),
    .rsp_err       (rsp_err),
    .aes_rst       (aes_rst),
    .aes_en        (aes_en),
    .aes_state     (aes_state),
    .aes_key       (aes_key),
    .aes_done      (aes_done),
    .aes_state_out (aes_state_out)
  );

  // ---------------- core model ----------------
  // Known FIPS-197 vector returns its ciphertext; anything else returns
  // pt ^ key[127:0] ^ {64'h0, key[191:128]}.
  logic         core_hang  = 1'b0;
  logic         force_done = 1'b0;
  logic         mdone      = 1'b0;
  int unsigned  ccnt       = 0;
  logic [127:0] core_out   = '0;

  function automatic logic [127:0] core_f(input logic [127:0] st, input logic [191:0] k);
    if (st == FIPS_PT && k == FIPS_KEY) return FIPS_CT;
    return st ^ k[127:0] ^ {64'h0, k[191:128]};
  endfunction

  always @(posedge clk) begin
    if (aes_rst || !aes_en) begin
      ccnt  <= 0;
      mdone <= 1'b0;
    end else if (!core_hang) begin
      core_out <= core_f(aes_state, aes_key);
      if (ccnt == CORE_CYC - 1) mdone <= 1'b1;
      else ccnt <= ccnt + 1;
    end
  end

  assign aes_done      = mdone | force_done;
  assign aes_state_out = force_done ? GARBAGE : core_out;

  // ---------------- stimulus tables (hand-computed expectations) ----------------
  logic [127:0] pt_tab  [N];
  logic [191:0] key_tab [N];
  logic [127:0] exp_tab [N];

  initial begin
    pt_tab[0]  = {4{32'h11111111}};
    key_tab[0] = {64'h00000000000000ff, {4{32'h0f0f0f0f}}};
    exp_tab[0] = 128'h1e1e1e1e_1e1e1e1e_1e1e1e1e_1e1e1ee1;
    pt_tab[1]  = {4{32'h22222222}};
    key_tab[1] = {64'h0, {4{32'hf0f0f0f0}}};
    exp_tab[1] = 128'hd2d2d2d2_d2d2d2d2_d2d2d2d2_d2d2d2d2;
    pt_tab[2]  = FIPS_PT;
    key_tab[2] = FIPS_KEY;
    exp_tab[2] = FIPS_CT;
    pt_tab[3]  = {4{32'h44444444}};
    key_tab[3] = {64'h1, {4{32'h0000ffff}}};
    exp_tab[3] = 128'h4444bbbb_4444bbbb_4444bbbb_4444bbba;
    for (int i = 0; i < N; i++) begin
      req_state[i*128 +: 128] = pt_tab[i];
      req_key[i*KL +: KL]     = key_tab[i];
    end
  end

  // ---------------- checking ----------------
  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [127:0] data;
    logic [1:0]   id;
    logic         err;
  } exp_t;

  exp_t exp_q[$];

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic push_exp(input logic [127:0] d, input logic [1:0] id, input logic e);
    exp_t x;
    x.data = d;
    x.id   = id;
    x.err  = e;
    exp_q.push_back(x);
  endtask

  // Monitor: pops one expectation per completed response handshake.
  initial forever begin
    @(negedge clk);
    #2;
    if (rst && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rsp_unexpected actual id=%0d data=%0h expected no response", rsp_id, rsp_data);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("rsp_data", rsp_data, e.data);
        chk("rsp_id", rsp_id, e.id);
        chk("rsp_err", rsp_err, e.err);
      end
    end
  end

  task automatic check_reset_vals(input string nm);
    chk({nm, "_req_ready"}, req_ready, 0);
    chk({nm, "_rsp_valid"}, rsp_valid, 0);
    chk({nm, "_rsp_data"}, rsp_data, 0);
    chk({nm, "_rsp_id"}, rsp_id, 0);
    chk({nm, "_rsp_err"}, rsp_err, 0);
    chk({nm, "_aes_rst"}, aes_rst, 1);
    chk({nm, "_aes_en"}, aes_en, 0);
    chk({nm, "_aes_state"}, aes_state, 0);
    chk({nm, "_aes_key"}, aes_key, 0);
  endtask

  task automatic do_reset(input string nm);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_reset_vals(nm);
    @(negedge clk);
    rst = 1'b1;
  endtask

  // Call at a falling edge; raises req_valid[idx] until granted, drops it on
  // the falling edge after the grant edge.
  task automatic send_one(input int idx);
    bit got;
    got = 1'b0;
    req_valid[idx] = 1'b1;
    for (int c = 0; c < 50 && !got; c++) begin
      #1;
      if (req_ready[idx]) got = 1'b1;
      @(negedge clk);
    end
    req_valid[idx] = 1'b0;
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL grant_timeout_%0d actual=no_grant expected=grant", idx);
    end
  endtask

  task automatic wait_rsp(input string nm);
    int c;
    c = 0;
    #1;
    while (!rsp_valid && c < 100) begin
      @(negedge clk);
      #1;
      c++;
    end
    if (!rsp_valid) begin
      checks++;
      errors++;
      $display("FAIL %s_rsp_timeout actual=0 expected=1", nm);
    end
  endtask

  task automatic wait_drain(input string nm);
    int c;
    c = 0;
    while (exp_q.size() != 0 && c < 200) begin
      @(negedge clk);
      c++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL %s_drain actual_pending=%0d expected=0", nm, exp_q.size());
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int          k;
    int          ng;
    int          n;
    int          order [5];
    logic [3:0]  eg;

    order     = '{0, 1, 2, 3, 0};
    rst       = 1'b0;
    req_valid = '0;
    rsp_ready = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_vals("por");
    rst = 1'b1;

    // T1: FIPS-197 C.2 vector from requester 2, plus grant-to-valid latency
    @(negedge clk);
    rsp_ready = 1'b1;
    push_exp(FIPS_CT, 2'd2, 1'b0);
    send_one(2);
    k = 1;
    #1;
    while (!rsp_valid && k < 100) begin
      if (aes_en) begin
        chk("t1_aes_key", aes_key, FIPS_KEY);
        chk("t1_aes_state", aes_state, FIPS_PT);
      end
      @(negedge clk);
      #1;
      k++;
    end
    // k counts falling edges from the one right after the grant edge
    chk("t1_latency", k - 1, 2 + CORE_CYC);
    wait_drain("t1");

    // T2: all requesters held valid from reset -> 0,1,2,3,0
    do_reset("t2rst");
    for (int i = 0; i < 5; i++) push_exp(exp_tab[order[i]], 2'(order[i]), 1'b0);
    rsp_ready = 1'b1;
    req_valid = '1;
    ng = 0;
    for (int c = 0; c < 300 && ng < 5; c++) begin
      #1;
      if (req_ready != 0) begin
        eg = 4'(1 << order[ng]);
        chk("t2_grant", req_ready, eg);
        ng++;
      end
      @(negedge clk);
    end
    req_valid = '0;
    chk("t2_grant_count", ng, 5);
    wait_drain("t2");

    // T3: back-pressure for 10 cycles with requester 3 waiting (rr_ptr = 1)
    rsp_ready = 1'b0;
    push_exp(exp_tab[1], 2'd1, 1'b0);
    push_exp(exp_tab[3], 2'd3, 1'b0);
    req_valid[3] = 1'b1;
    send_one(1);
    wait_rsp("t3");
    for (int i = 0; i < 10; i++) begin
      chk("t3_hold_valid", rsp_valid, 1);
      chk("t3_hold_data", rsp_data, exp_tab[1]);
      chk("t3_hold_id", rsp_id, 1);
      chk("t3_no_req_ready", req_ready, 0);
      @(negedge clk);
      #1;
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    #1;
    chk("t3_next_grant", req_ready, 4'b1000);
    @(negedge clk);
    req_valid[3] = 1'b0;
    wait_drain("t3");

    // T4: reset mid-RUN aborts; rr_ptr returns to 0
    send_one(2);
    @(negedge clk);
    #1;
    chk("t4_in_run", aes_en, 1);
    rst = 1'b0;
    #1;
    check_reset_vals("t4rst");
    @(negedge clk);
    rst = 1'b1;
    push_exp(exp_tab[0], 2'd0, 1'b0);
    req_valid = '1;
    #1;
    chk("t4_rr_ptr_zero", req_ready, 4'b0001);
    @(negedge clk);
    req_valid = '0;
    wait_drain("t4");

`ifdef AES_ARB_TIMEOUT_EN
    // T5: core hangs -> watchdog response, then a normal operation
    core_hang = 1'b1;
    push_exp('0, 2'd1, 1'b1);
    send_one(1);
    n = 0;
    k = 0;
    #1;
    while (!rsp_valid && k < 100) begin
      if (aes_en) n++;
      @(negedge clk);
      #1;
      k++;
    end
    chk("t5_run_cycles", n, TO);
    core_hang = 1'b0;
    wait_drain("t5a");
    @(negedge clk);
    push_exp(exp_tab[3], 2'd3, 1'b0);
    send_one(3);
    wait_drain("t5b");
`endif

    // T6: aes_done ignored in IDLE and RESP
    @(negedge clk);
    force_done = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("t6_idle_done", rsp_valid, 0);
      @(negedge clk);
    end
    force_done = 1'b0;
    rsp_ready  = 1'b0;
    push_exp(exp_tab[0], 2'd0, 1'b0);
    send_one(0);
    wait_rsp("t6");
    force_done = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("t6_resp_valid", rsp_valid, 1);
      chk("t6_resp_data", rsp_data, exp_tab[0]);
      @(negedge clk);
      #1;
    end
    force_done = 1'b0;
    rsp_ready  = 1'b1;
    wait_drain("t6");
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #1;
      chk("t6_no_extra", rsp_valid, 0);
    end

    chk("final_queue_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog actual=timeout expected=finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "simulation watchdog expired");
  end

endmodule
